// File: rtl/instr_encoder_loader_if.sv
// Command and instruction-memory write bundle for instr_encoder_loader.
// master: command source + memory side; slave: the loader itself.
`timescale 1ns/1ps
interface instr_encoder_loader_if #(
   parameter int ADDR_W = 8
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [4:0]        cmd_op;
   logic [4:0]        cmd_ra;
   logic [4:0]        cmd_rb;
   logic [4:0]        cmd_rt;
   logic [20:0]       cmd_imm;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              im_ack;

   modport master (
      output cmd_valid, cmd_op, cmd_ra, cmd_rb,
      output cmd_rt, cmd_imm, im_ack,
      input  cmd_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_ra, cmd_rb,
      input  cmd_rt, cmd_imm, im_ack,
      output cmd_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic commands into 32-bit words,
// buffers them and writes them sequentially into instruction memory.
// Ports: clk, rst_n (async low); start/finish/base_addr control the run;
// bus (slave) carries cmd_* handshake and the im_* held-until-ack write
// port; busy/done/err_opcode/err_overflow/words_written report status.
`timescale 1ns/1ps
module instr_encoder_loader #(
   parameter int ADDR_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 finish,
   input  logic [ADDR_W-1:0]    base_addr,
   instr_encoder_loader_if.slave bus,
   output logic                 busy,
   output logic                 done,
   output logic                 err_opcode,
   output logic                 err_overflow,
   output logic [ADDR_W:0]      words_written
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0] SPACE = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   typedef enum logic [2:0] {
      F_NONE,
      F_ALU,
      F_LD,
      F_ST,
      F_LDIL,
      F_BL,
      F_CMB,
      F_IMM
   } fmt_t;

   state_t state_q, state_d;

   logic [ADDR_W:0]   room_q;
   logic [ADDR_W:0]   pushed_q;
   logic              err_op_q;
   logic              err_ovf_q;

   logic [31:0]       mem_q [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q;
   logic [PW-1:0]     rd_ptr_q;
   logic [PW:0]       count_q;

   logic              im_we_q;
   logic [ADDR_W-1:0] im_addr_q;
   logic [31:0]       im_wdata_q;
   logic [ADDR_W:0]   written_q;

   logic              run;
   logic              start_ok;
   logic              fifo_full;
   logic              space_left;
   logic              ready;
   logic              accept;
   logic              legal;
   logic              push;
   logic              pop;
   logic              ovf_hit;

   fmt_t              fmt;
   logic [5:0]        opc;
   logic [5:0]        op2;
   logic [13:0]       lse14;
   logic [10:0]       lse11;
   logic [31:0]       enc_word;

   // ---------------- control ----------------
   assign run        = (state_q == S_RUN);
   assign start_ok   = start &&
                       (state_q == S_IDLE ||
                        state_q == S_DONE);
   assign fifo_full  = (count_q == FULL_CNT);
   // room_q is how many words fit between base_addr and the top
   assign space_left = (pushed_q < room_q);
   assign ready      = run && !fifo_full &&
                       !err_ovf_q && space_left;
   assign accept     = bus.cmd_valid && ready;
   assign legal      = (bus.cmd_op <= 5'd21);
   assign push       = accept && legal;
   assign pop        = im_we_q && bus.im_ack;
   assign ovf_hit    = run && bus.cmd_valid && !space_left;

   assign bus.cmd_ready = ready;
   assign bus.im_we     = im_we_q;
   assign bus.im_addr   = im_addr_q;
   assign bus.im_wdata  = im_wdata_q;

   assign busy          = (state_q == S_RUN) ||
                          (state_q == S_DRAIN);
   assign done          = (state_q == S_DONE);
   assign err_opcode    = err_op_q;
   assign err_overflow  = err_ovf_q;
   assign words_written = written_q;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            if (finish) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (count_q == '0 && !im_we_q)
               state_d = S_DONE;
         end
         S_DONE: begin
            if (start) state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- encoder ----------------
   // sign bit rotated into the LSB of the displacement fields
   assign lse14 = {bus.cmd_imm[12:0], bus.cmd_imm[13]};
   assign lse11 = {bus.cmd_imm[9:0], bus.cmd_imm[10]};

   always_comb begin
      fmt = F_NONE;
      opc = 6'b000000;
      op2 = 6'b000000;
      unique case (bus.cmd_op)
         5'd1: begin fmt = F_ALU; op2 = 6'b011000; end
         5'd2: begin fmt = F_ALU; op2 = 6'b011100; end
         5'd3: begin fmt = F_ALU; op2 = 6'b101000; end
         5'd4: begin fmt = F_ALU; op2 = 6'b010000; end
         5'd5: begin fmt = F_ALU; op2 = 6'b010100; end
         5'd6: begin fmt = F_ALU; op2 = 6'b001001; end
         5'd7: begin fmt = F_ALU; op2 = 6'b001010; end
         5'd8: begin fmt = F_ALU; op2 = 6'b001000; end
         5'd9:  begin fmt = F_LD; opc = 6'b010010; end
         5'd10: begin fmt = F_LD; opc = 6'b010001; end
         5'd11: begin fmt = F_LD; opc = 6'b010000; end
         5'd12: begin fmt = F_LD; opc = 6'b001101; end
         5'd13: begin fmt = F_LDIL; opc = 6'b001000; end
         5'd14: begin fmt = F_ST; opc = 6'b011010; end
         5'd15: begin fmt = F_ST; opc = 6'b011001; end
         5'd16: begin fmt = F_ST; opc = 6'b011000; end
         5'd17: begin fmt = F_BL; opc = 6'b111010; end
         5'd18: begin fmt = F_CMB; opc = 6'b100000; end
         5'd19: begin fmt = F_CMB; opc = 6'b100010; end
         5'd20: begin fmt = F_IMM; opc = 6'b101101; end
         5'd21: begin fmt = F_IMM; opc = 6'b100101; end
         default: fmt = F_NONE;
      endcase
   end

   always_comb begin
      enc_word = 32'h0;
      unique case (fmt)
         F_ALU:
            enc_word = {6'b000010, bus.cmd_rb,
                        bus.cmd_ra, 4'b0000, op2,
                        1'b0, bus.cmd_rt};
         F_LD:
            enc_word = {opc, bus.cmd_rb, bus.cmd_rt,
                        2'b00, lse14};
         F_ST:
            enc_word = {opc, bus.cmd_rb, bus.cmd_ra,
                        2'b00, lse14};
         F_LDIL:
            enc_word = {opc, bus.cmd_rt, bus.cmd_imm};
         F_BL:
            enc_word = {opc, bus.cmd_rt,
                        bus.cmd_imm[18:0], 2'b00};
         F_CMB:
            enc_word = {opc, bus.cmd_rb, bus.cmd_ra,
                        bus.cmd_rt[2:0],
                        bus.cmd_imm[10:0], 2'b00};
         F_IMM:
            enc_word = {opc, bus.cmd_ra, bus.cmd_rt,
                        5'b00000, lse11};
         default: enc_word = 32'h0;
      endcase
   end

   // ---------------- run counters / flags ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         room_q    <= '0;
         pushed_q  <= '0;
         err_op_q  <= 1'b0;
         err_ovf_q <= 1'b0;
      end else if (start_ok) begin
         room_q    <= SPACE - {1'b0, base_addr};
         pushed_q  <= '0;
         err_op_q  <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         if (push) pushed_q <= pushed_q + 1'b1;
         if (accept && !legal) err_op_q <= 1'b1;
         if (ovf_hit) err_ovf_q <= 1'b1;
      end
   end

   // ---------------- FIFO ----------------
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= enc_word;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (start_ok) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------- write port ----------------
   // The head stays in the FIFO until acknowledged, so the in-flight
   // word still occupies a slot; the port idles one cycle after ack.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         im_we_q    <= 1'b0;
         im_addr_q  <= '0;
         im_wdata_q <= '0;
         written_q  <= '0;
      end else if (start_ok) begin
         im_we_q    <= 1'b0;
         im_addr_q  <= base_addr;
         written_q  <= '0;
      end else if (pop) begin
         im_we_q   <= 1'b0;
         written_q <= written_q + 1'b1;
         // saturate at the top word instead of wrapping to 0
         if (im_addr_q != {ADDR_W{1'b1}})
            im_addr_q <= im_addr_q + 1'b1;
      end else if (!im_we_q && count_q != '0) begin
         im_we_q    <= 1'b1;
         im_wdata_q <= mem_q[rd_ptr_q];
      end
   end

endmodule
